adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
- Hardware sequencer for one ADC driver channel; replaces the software bit-banging of the driver's GPIO control lines.
- On `start` it performs four steps, all on the pl_clk domain:
  - serially loads the run-cycle and shift-value config registers;
  - fires 2^shift_val capture triggers with fixed spacing;
  - reloads shift_val = 0 to enable readout;
  - flags completion.
- Sits between the PS GPIO/config block and the ADC driver's gpio_ctrl/select inputs.

Parameters:
- CFG_W, 32, width of each serial config register (matches config_reg_width).
- HOLD_CYCLES, 2, pl_clk cycles per serial phase (data setup, clk high, clk low).
- TRIG_GAP, 50, low cycles after each trigger pulse before the next trigger.
- MAX_SHIFT, 8, largest accepted shift_val; the trigger counter is MAX_SHIFT+1 bits.

Ports:
- pl_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- run_cycles  in  CFG_W  capture cycle count to load; latched on accepted start.
- shift_val  in  CFG_W  averaging shift; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  one-cycle pulse when start is rejected.
- sdata  out  1  serial config data, LSB first.
- cycle_cnt_clk  out  1  shift clock for the run-cycle register.
- shift_val_clk  out  1  shift clock for the shift-value register.
- trigger  out  1  capture trigger to the ADC driver.
- select_out  out  1  config-select qualifier to the ADC driver.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latched registers cleared. Reset asserted mid-sequence aborts immediately: outputs drop to 0 asynchronously; no done pulse.
- Start acceptance:
  - start in IDLE with shift_val <= MAX_SHIFT: latch run_cycles and shift_val, go to LOAD_CYC.
  - start in IDLE with shift_val > MAX_SHIFT: err pulses the next cycle, FSM stays IDLE, nothing is latched.
  - start in any non-IDLE state is ignored, with no err.
- Serial load procedure (used by LOAD_CYC, LOAD_SHIFT, LOAD_ZERO):
  - select_out rises for 1 cycle before the first bit and stays high throughout the load.
  - Each bit i = 0..CFG_W-1 takes three phases of HOLD_CYCLES each:
    - sdata = bit i, the target clk low;
    - target clk high (sdata held);
    - target clk low (sdata held).
  - select_out falls 1 cycle after the last phase.
  - Load length = CFG_W*3*HOLD_CYCLES + 2 cycles.
  - sdata returns to 0 outside loads.
  - Only the target clk toggles; the other clk stays 0.
- State sequence:
  - IDLE -> LOAD_CYC: load run_cycles on cycle_cnt_clk.
  - LOAD_CYC -> LOAD_SHIFT: load shift_val on shift_val_clk.
  - LOAD_SHIFT -> TRIG: trigger high exactly 1 cycle.
  - TRIG -> GAP: trigger low for TRIG_GAP cycles.
  - GAP -> TRIG while issued triggers < 2^shift_val; otherwise GAP -> LOAD_ZERO.
  - LOAD_ZERO: load all-zero on shift_val_clk.
  - LOAD_ZERO -> DONE: done = 1 for 1 cycle, busy still 1.
  - DONE -> IDLE.
- Trigger count:
  - Counter width MAX_SHIFT+1; target = 1 << shift_val.
  - shift_val = 0 gives exactly 1 trigger; shift_val = MAX_SHIFT gives 2^MAX_SHIFT triggers.
- Total latency from start to done = 3*(CFG_W*3*HOLD_CYCLES + 2) + 2^shift_val*(1+TRIG_GAP) + 1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro ADC_SEQ_ABORT_EN adds input port `abort` (1 bit).
- With the macro: abort high in any state other than IDLE/DONE ends the current serial phase boundary, forces select_out, the clks, sdata and trigger to 0 next cycle, and goes to IDLE with no done pulse. A partially loaded register is left as is; the next start reloads both registers.
- Without the macro: no abort port; a sequence can only be stopped by rst.

Test Plan:
- Bench settings: CFG_W=16, HOLD_CYCLES=2, TRIG_GAP=50.
- Case 1: start with run_cycles=4, shift_val=2 -> exactly 4 trigger pulses 51 cycles apart; done at start+3*98+204+1; the bits captured on cycle_cnt_clk rising edges decode to 0x0004.
- Case 2: capture sdata on shift_val_clk rising edges -> first load decodes 0x0002, second load decodes 0x0000; 16 rising edges each; cycle_cnt_clk silent during both.
- Case 3: shift_val=0 -> exactly 1 trigger; shift_val=8 -> 256 triggers; shift_val=9 -> err pulse, busy stays 0, no clk activity.
- Case 4: start pulsed again during GAP -> ignored; trigger count unchanged (4); single done pulse.
- Case 5: rst asserted mid LOAD_SHIFT -> all outputs 0 asynchronously, busy=0; a fresh start afterwards runs the full sequence correctly.
- Case 6 (ADC_SEQ_ABORT_EN defined): abort during the 2nd trigger gap -> no further triggers, no LOAD_ZERO activity, no done; busy=0 within one phase plus 1 cycle.

Source files
------------

// File: rtl/adc_capture_sequencer_if.sv
// Control/status and ADC-driver signal bundle for adc_capture_sequencer.
// The abort line exists only when ADC_SEQ_ABORT_EN is defined.
interface adc_capture_sequencer_if #(
  parameter int CFG_W = 32
);
  logic             start;
  logic [CFG_W-1:0] run_cycles;
  logic [CFG_W-1:0] shift_val;
  logic             busy;
  logic             done;
  logic             err;
  logic             sdata;
  logic             cycle_cnt_clk;
  logic             shift_val_clk;
  logic             trigger;
  logic             select_out;
`ifdef ADC_SEQ_ABORT_EN
  logic             abort;

  modport master (
    output start, run_cycles, shift_val, abort,
    input  busy, done, err, sdata, cycle_cnt_clk,
    input  shift_val_clk, trigger, select_out
  );

  modport slave (
    input  start, run_cycles, shift_val, abort,
    output busy, done, err, sdata, cycle_cnt_clk,
    output shift_val_clk, trigger, select_out
  );
`else
  modport master (
    output start, run_cycles, shift_val,
    input  busy, done, err, sdata, cycle_cnt_clk,
    input  shift_val_clk, trigger, select_out
  );

  modport slave (
    input  start, run_cycles, shift_val,
    output busy, done, err, sdata, cycle_cnt_clk,
    output shift_val_clk, trigger, select_out
  );
`endif
endinterface

// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer: serial config loads, 2^shift trigger burst, readout reload.
// Define ADC_SEQ_ABORT_EN to add the abort input.
module adc_capture_sequencer #(
  parameter int CFG_W       = 32,
  parameter int HOLD_CYCLES = 2,
  parameter int TRIG_GAP    = 50,
  parameter int MAX_SHIFT   = 8
) (
  input logic                    pl_clk,
  input logic                    rst,
  adc_capture_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_CYC, LOAD_SHIFT, TRIG, GAP, LOAD_ZERO, DONE
  } state_t;

  typedef enum logic [2:0] {
    S_PRE, S_SETUP, S_HIGH, S_LOW, S_POST
  } seg_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int GW = (TRIG_GAP > 1) ? $clog2(TRIG_GAP) : 1;
  localparam int TW = MAX_SHIFT + 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_W - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(TRIG_GAP - 1);
  localparam logic [CFG_W-1:0] SHIFT_MAX = CFG_W'(MAX_SHIFT);

  state_t           state_q, state_n;
  seg_t             seg_q, seg_n;
  logic [HW-1:0]    hold_q, hold_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic [TW-1:0]    tcnt_q, tcnt_n;
  logic [CFG_W-1:0] run_q, run_n;
  logic [CFG_W-1:0] shift_q, shift_n;

  logic busy_q, busy_n;
  logic done_q, done_n;
  logic err_q, err_n;
  logic sdata_q, sdata_n;
  logic cclk_q, cclk_n;
  logic sclk_q, sclk_n;
  logic trig_q, trig_n;
  logic sel_q, sel_n;

  logic [TW-1:0] tgt;
  logic          phase_end;
  logic          load_n;
  logic          bit_on;
  logic          dbit;

  assign tgt       = TW'(1) << shift_q;
  assign phase_end = (hold_q == HOLD_LAST);

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seg_q   <= S_PRE;
      hold_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tcnt_q  <= '0;
      run_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sdata_q <= 1'b0;
      cclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      trig_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      seg_q   <= seg_n;
      hold_q  <= hold_n;
      bit_q   <= bit_n;
      gap_q   <= gap_n;
      tcnt_q  <= tcnt_n;
      run_q   <= run_n;
      shift_q <= shift_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      sdata_q <= sdata_n;
      cclk_q  <= cclk_n;
      sclk_q  <= sclk_n;
      trig_q  <= trig_n;
      sel_q   <= sel_n;
    end
  end

  always_comb begin
    state_n = state_q;
    seg_n   = seg_q;
    hold_n  = hold_q;
    bit_n   = bit_q;
    gap_n   = gap_q;
    tcnt_n  = tcnt_q;
    run_n   = run_q;
    shift_n = shift_q;
    err_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.shift_val <= SHIFT_MAX) begin
            state_n = LOAD_CYC;
            run_n   = bus.run_cycles;
            shift_n = bus.shift_val;
            seg_n   = S_PRE;
            hold_n  = '0;
            bit_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOAD_CYC, LOAD_SHIFT, LOAD_ZERO: begin
        unique case (seg_q)
          S_PRE: seg_n = S_SETUP;
          S_SETUP, S_HIGH, S_LOW: begin
            if (phase_end) begin
              hold_n = '0;
              if (seg_q == S_SETUP) begin
                seg_n = S_HIGH;
              end else if (seg_q == S_HIGH) begin
                seg_n = S_LOW;
              end else if (bit_q == BIT_LAST) begin
                seg_n = S_POST;
              end else begin
                seg_n = S_SETUP;
                bit_n = bit_q + 1'b1;
              end
            end else begin
              hold_n = hold_q + 1'b1;
            end
          end
          S_POST: begin
            seg_n = S_PRE;
            bit_n = '0;
            if (state_q == LOAD_CYC) begin
              state_n = LOAD_SHIFT;
            end else if (state_q == LOAD_SHIFT) begin
              state_n = TRIG;
              tcnt_n  = TW'(1);
            end else begin
              state_n = DONE;
            end
          end
          default: seg_n = S_PRE;
        endcase
      end
      TRIG: begin
        state_n = GAP;
        gap_n   = '0;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (tcnt_q < tgt) begin
            state_n = TRIG;
            tcnt_n  = tcnt_q + 1'b1;
          end else begin
            state_n = LOAD_ZERO;
          end
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

`ifdef ADC_SEQ_ABORT_EN
    if (bus.abort && state_q != IDLE && state_q != DONE) begin
      state_n = IDLE;
      seg_n   = S_PRE;
      hold_n  = '0;
      bit_n   = '0;
    end
`endif

    // Outputs are decoded from the next state so they leave the flops aligned with it
    load_n = (state_n == LOAD_CYC) || (state_n == LOAD_SHIFT) ||
             (state_n == LOAD_ZERO);
    bit_on = (seg_n == S_SETUP) || (seg_n == S_HIGH) || (seg_n == S_LOW);
    case (state_n)
      LOAD_CYC:   dbit = run_n[bit_n];
      LOAD_SHIFT: dbit = shift_n[bit_n];
      default:    dbit = 1'b0;
    endcase

    sel_n   = load_n && (seg_n != S_POST);
    sdata_n = load_n && bit_on && dbit;
    cclk_n  = (state_n == LOAD_CYC) && (seg_n == S_HIGH);
    sclk_n  = ((state_n == LOAD_SHIFT) || (state_n == LOAD_ZERO)) &&
              (seg_n == S_HIGH);
    trig_n  = (state_n == TRIG);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.sdata         = sdata_q;
  assign bus.cycle_cnt_clk = cclk_q;
  assign bus.shift_val_clk = sclk_q;
  assign bus.trigger       = trig_q;
  assign bus.select_out    = sel_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Scoreboard bench for adc_capture_sequencer (CFG_W=16, HOLD_CYCLES=2, TRIG_GAP=50).
// Define ADC_SEQ_ABORT_EN to also exercise abort.
module tb_adc_capture_sequencer;

  localparam int CFG_W = 16;
  localparam int HOLD  = 2;
  localparam int GAP   = 50;
  localparam int MAXS  = 8;
  localparam int LOADL = CFG_W * 3 * HOLD + 2;

  typedef struct {
    bit          is_err;
    int          start_cyc;
    int          ntrig;
    logic [15:0] run;
    logic [15:0] shift;
  } exp_t;

  typedef struct {
    bit          cc;
    bit          sv;
    int          edges;
    logic [15:0] val;
  } load_t;

  logic pl_clk = 1'b0;
  logic rst    = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   failures = 0;
  bit   clr_req = 1'b0;

  exp_t  exp_q[$];
  load_t loads[$];
  int    trig_cyc[$];
  bit    trig_wide;
  bit    cur_cc, cur_sv;
  int    cur_edges;
  logic [15:0] cur_val;
  logic  prev_cc, prev_sv, prev_sel, prev_trig;

  adc_capture_sequencer_if #(.CFG_W(CFG_W)) bus ();

  adc_capture_sequencer #(
    .CFG_W(CFG_W),
    .HOLD_CYCLES(HOLD),
    .TRIG_GAP(GAP),
    .MAX_SHIFT(MAXS)
  ) dut (
    .pl_clk(pl_clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 pl_clk = ~pl_clk;
  always @(posedge pl_clk) cyc <= cyc + 1;

  function automatic logic [7:0] outs();
    return {bus.busy, bus.done, bus.err, bus.sdata, bus.cycle_cnt_clk,
            bus.shift_val_clk, bus.trigger, bus.select_out};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    loads.delete();
    trig_cyc.delete();
    trig_wide = 1'b0;
    cur_cc    = 1'b0;
    cur_sv    = 1'b0;
    cur_edges = 0;
    cur_val   = '0;
  endtask

  function automatic longint pack(input bit cc, input bit sv,
                                  input int edges, input logic [15:0] v);
    return {38'd0, cc, sv, edges[7:0], v};
  endfunction

  task automatic check_done();
    exp_t e;
    int   bad;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("done_not_err", e.is_err, 0);
      chk("done_cycle", cyc,
          e.start_cyc + 3 * LOADL + e.ntrig * (1 + GAP) + 1);
      chk("busy_at_done", bus.busy, 1);
      chk("trig_count", trig_cyc.size(), e.ntrig);
      bad = int'(trig_wide);
      foreach (trig_cyc[i])
        if (trig_cyc[i] != e.start_cyc + 2 * LOADL + 1 + i * (1 + GAP))
          bad++;
      chk("trig_timing", bad, 0);
      chk("load_count", loads.size(), 3);
      if (loads.size() == 3) begin
        chk("load_run",
            pack(loads[0].cc, loads[0].sv, loads[0].edges, loads[0].val),
            pack(1'b1, 1'b0, CFG_W, e.run));
        chk("load_shift",
            pack(loads[1].cc, loads[1].sv, loads[1].edges, loads[1].val),
            pack(1'b0, 1'b1, CFG_W, e.shift));
        chk("load_zero",
            pack(loads[2].cc, loads[2].sv, loads[2].edges, loads[2].val),
            pack(1'b0, 1'b1, CFG_W, 16'h0000));
      end
    end
    clear_obs();
  endtask

  task automatic check_err();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_err", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("err_flag", e.is_err, 1);
      chk("err_cycle", cyc, e.start_cyc + 1);
      chk("err_busy", bus.busy, 0);
      chk("err_quiet",
          loads.size() + trig_cyc.size() + cur_edges + int'(bus.select_out), 0);
    end
  endtask

  // Monitor: reconstructs serial words and trigger times, checks at done/err
  initial begin
    clear_obs();
    prev_cc = 0; prev_sv = 0; prev_sel = 0; prev_trig = 0;
    forever begin
      @(negedge pl_clk);
      if (rst || clr_req) begin
        clear_obs();
      end else begin
        if (bus.cycle_cnt_clk && bus.shift_val_clk)
          chk("both_clks_high", 1, 0);
        if (bus.cycle_cnt_clk && !prev_cc) begin
          if (cur_edges < 16) cur_val[cur_edges] = bus.sdata;
          cur_edges++;
          cur_cc = 1'b1;
        end
        if (bus.shift_val_clk && !prev_sv) begin
          if (cur_edges < 16) cur_val[cur_edges] = bus.sdata;
          cur_edges++;
          cur_sv = 1'b1;
        end
        if (prev_sel && !bus.select_out) begin
          loads.push_back('{cur_cc, cur_sv, cur_edges, cur_val});
          cur_cc = 0; cur_sv = 0; cur_edges = 0; cur_val = '0;
        end
        if (bus.trigger && !prev_trig) trig_cyc.push_back(cyc);
        if (bus.trigger && prev_trig) trig_wide = 1'b1;
        if (bus.done) check_done();
        if (bus.err) check_err();
      end
      prev_cc   = bus.cycle_cnt_clk;
      prev_sv   = bus.shift_val_clk;
      prev_sel  = bus.select_out;
      prev_trig = bus.trigger;
    end
  end

  task automatic issue(input logic [15:0] rc, input logic [15:0] sv);
    exp_t e;
    e.is_err    = (sv > 16'(MAXS));
    e.start_cyc = cyc;
    e.run       = rc;
    e.shift     = sv;
    e.ntrig     = e.is_err ? 0 : (1 << sv);
    exp_q.push_back(e);
    bus.start      = 1'b1;
    bus.run_cycles = rc;
    bus.shift_val  = sv;
    @(negedge pl_clk);
    bus.start      = 1'b0;
    bus.run_cycles = 16'($urandom);
    bus.shift_val  = 16'($urandom);
  endtask

  task automatic flush();
    exp_q.delete();
    clr_req = 1'b1;
    repeat (2) @(negedge pl_clk);
    clr_req = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge pl_clk);
      n++;
    end
    chk("seq_timeout", exp_q.size(), 0);
    if (exp_q.size() != 0) flush();
  endtask

  task automatic run_seq(input logic [15:0] rc, input logic [15:0] sv,
                         input bit restart);
    bit err_case = (sv > 16'(MAXS));
    int nt       = err_case ? 0 : (1 << sv);
    issue(rc, sv);
    if (restart && !err_case) begin
      repeat (2 * LOADL + GAP) @(negedge pl_clk);
      bus.start      = 1'b1;
      bus.run_cycles = 16'($urandom);
      bus.shift_val  = 16'($urandom_range(0, MAXS));
      @(negedge pl_clk);
      bus.start = 1'b0;
    end
    wait_idle(4 * LOADL + nt * (GAP + 1) + 20);
    if (err_case) begin
      repeat (3) @(negedge pl_clk);
      chk("err_stays_idle", outs(), 0);
    end
    repeat (2) @(negedge pl_clk);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.run_cycles = '0;
    bus.shift_val  = '0;
`ifdef ADC_SEQ_ABORT_EN
    bus.abort      = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge pl_clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (2) @(negedge pl_clk);
    chk("idle_outputs", outs(), 0);

    run_seq(16'h0004, 16'd2, 1'b0);
    run_seq(16'hA5C3, 16'd0, 1'b0);
    run_seq(16'h7E81, 16'd8, 1'b0);
    run_seq(16'h1234, 16'd9, 1'b0);
    run_seq(16'h0004, 16'd2, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] rc, sv;
      rc = 16'($urandom);
      if ($urandom_range(0, 4) == 0) sv = 16'($urandom_range(9, 65535));
      else sv = 16'($urandom_range(0, 4));
      run_seq(rc, sv, ($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of the shift-value load
    issue(16'h00F0, 16'd2);
    repeat (LOADL + 30) @(negedge pl_clk);
    chk("pre_rst_load", {bus.busy, bus.select_out}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", outs(), 0);
    exp_q.delete();
    repeat (3) @(negedge pl_clk);
    rst = 1'b0;
    repeat (2) @(negedge pl_clk);
    run_seq(16'hBEEF, 16'd3, 1'b0);

`ifdef ADC_SEQ_ABORT_EN
    begin
      int n;
      issue(16'h0C0C, 16'd2);
      n = 0;
      while (trig_cyc.size() < 2 && n < 3 * LOADL + 200) begin
        @(negedge pl_clk);
        n++;
      end
      chk("abort_reach_gap2", trig_cyc.size(), 2);
      repeat (10) @(negedge pl_clk);
      bus.abort = 1'b1;
      @(negedge pl_clk);
      bus.abort = 1'b0;
      n = 0;
      while (bus.busy && n < HOLD + 1) begin
        @(negedge pl_clk);
        n++;
      end
      chk("abort_busy", bus.busy, 0);
      repeat (LOADL + 300) @(negedge pl_clk);
      chk("abort_trigs", trig_cyc.size(), 2);
      chk("abort_loads", loads.size(), 2);
      chk("abort_no_done", exp_q.size(), 1);
      flush();
      run_seq(16'h5A5A, 16'd1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 90000);
    failures++;
    $display("FAIL watchdog: simulation did not finish within bound");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
